// File: rtl/axi4_frame_reader.sv
// AXI4 read master that streams one frame buffer into the pixel FIFO as
// fixed 64-beat INCR bursts, one frame per frame_start rising edge.
module axi4_frame_reader #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int FRAME_BYTES    = 153600
) (
    input  logic                      clk_100Mhz,
    input  logic                      rst,
    input  logic [AXI_ADDR_WIDTH-1:0] FRAME_BASE_ADDR,
    input  logic                      frame_start,
    input  logic                      fifo_prog_full,
    output logic [AXI_DATA_WIDTH-1:0] fifo_din,
    output logic                      fifo_wr_en,
    output logic [AXI_ADDR_WIDTH-1:0] ARADDR,
    output logic                      ARVALID,
    input  logic                      ARREADY,
    output logic [7:0]                ARLEN,
    output logic [2:0]                ARSIZE,
    output logic [1:0]                ARBURST,
    output logic [3:0]                ARCACHE,
    output logic [2:0]                ARPROT,
    input  logic [AXI_DATA_WIDTH-1:0] RDATA,
    input  logic                      RVALID,
    output logic                      RREADY,
    input  logic                      RLAST,
    input  logic [1:0]                RRESP,
    output logic                      reader_done,
    output logic                      frame_active,
    output logic                      err_resp,
    output logic                      err_last,
    output logic                      err_overrun,
    output logic [1:0]                state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADDR_SEND = 2'd1,
        DATA_RECV = 2'd2,
        NEXT      = 2'd3
    } state_t;

    localparam logic [31:0] LAST_OFFSET = 32'(FRAME_BYTES - 512);

    state_t                    st;
    logic                      fs_d;
    logic                      fs_edge;
    logic                      beat;
    logic [31:0]               offset;
    logic [AXI_ADDR_WIDTH-1:0] base;
    logic [7:0]                beat_cnt;

    assign fs_edge    = frame_start & ~fs_d;
    assign RREADY     = (st == DATA_RECV);
    assign beat       = RVALID & RREADY;
    assign fifo_wr_en = beat;
    assign fifo_din   = RDATA;
    assign state      = st;

    assign ARLEN   = 8'd63;
    assign ARSIZE  = 3'b011;
    assign ARBURST = 2'b01;
    assign ARCACHE = 4'b0011;
    assign ARPROT  = 3'b000;

    always_ff @(posedge clk_100Mhz or posedge rst) begin
        if (rst) begin
            st           <= IDLE;
            fs_d         <= 1'b0;
            offset       <= '0;
            base         <= '0;
            beat_cnt     <= '0;
            ARADDR       <= '0;
            ARVALID      <= 1'b0;
            reader_done  <= 1'b0;
            frame_active <= 1'b0;
            err_resp     <= 1'b0;
            err_last     <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            fs_d        <= frame_start;
            reader_done <= 1'b0;

            // A new edge mid-frame is only flagged; the running frame is untouched.
            if (fs_edge) begin
                if (frame_active) begin
                    err_overrun <= 1'b1;
                end else begin
                    frame_active <= 1'b1;
                    offset       <= '0;
                    base         <= FRAME_BASE_ADDR;
                end
            end

            case (st)
                IDLE: begin
                    if (frame_active && !fifo_prog_full) begin
                        ARADDR  <= base + AXI_ADDR_WIDTH'(offset);
                        ARVALID <= 1'b1;
                        st      <= ADDR_SEND;
                    end
                end
                ADDR_SEND: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        st      <= DATA_RECV;
                    end
                end
                DATA_RECV: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (RRESP != 2'b00) err_resp <= 1'b1;
                        // Burst ends only on RLAST, even if the slave overruns beat 63.
                        if (RLAST) begin
                            if (beat_cnt != 8'd63) err_last <= 1'b1;
                            st <= NEXT;
                        end else if (beat_cnt == 8'd63) begin
                            err_last <= 1'b1;
                        end
                    end
                end
                NEXT: begin
                    beat_cnt <= '0;
                    if (offset == LAST_OFFSET) begin
                        frame_active <= 1'b0;
                        reader_done  <= 1'b1;
                    end else begin
                        offset <= offset + 32'd512;
                    end
                    st <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi4_frame_reader.md
# axi4_frame_reader

AXI4 memory-mapped-to-stream read master that fetches one 320x240 RGB565 frame (153600 bytes) from DDR in 64-beat, 64-bit INCR bursts and pushes each beat into the external async pixel FIFO feeding the HDMI pixel-clock domain. It is the read-side counterpart of the camera frame writer and reads from the frame buffer that the writer fills. It is paced by FIFO back-pressure and started once per displayed frame.

## Interface
- AXI_ADDR_WIDTH, 32, AXI address width
- AXI_DATA_WIDTH, 64, AXI data width (4 pixels/beat)
- FRAME_BYTES, 153600, bytes per frame; must be a multiple of 512
- clk_100Mhz  in  1  AXI/system clock
- rst  in  1  asynchronous, active-high reset
- FRAME_BASE_ADDR  in  32  frame buffer base; sampled on accepted frame_start
- frame_start  in  1  level from display timing (clk_100Mhz-synchronous); rising edge starts a frame
- fifo_prog_full  in  1  FIFO cannot accept 64 more words
- fifo_din  out  64  equals RDATA
- fifo_wr_en  out  1  FIFO write strobe
- ARADDR  out  32  burst start address
- ARVALID  out  1  read address valid
- ARREADY  in  1  read address ready
- ARLEN/ARSIZE/ARBURST/ARCACHE/ARPROT  out  8/3/2/4/3  constants 63, 3'b011, 2'b01, 4'b0011, 3'b000
- RDATA  in  64  read data
- RVALID  in  1  read data valid
- RREADY  out  1  read data ready
- RLAST  in  1  last beat
- RRESP  in  2  read response
- reader_done  out  1  one-cycle pulse after the final burst of a frame
- frame_active  out  1  frame in progress
- err_resp  out  1  sticky: any beat with RRESP != 0
- err_last  out  1  sticky: RLAST not coincident with beat 63
- err_overrun  out  1  sticky: frame_start edge while frame_active
- state  out  2  FSM state (debug)

## Operation
- States: IDLE=0, ADDR_SEND=1, DATA_RECV=2, NEXT=3.
- frame_start rising edge (registered one-cycle delay detector), with frame_active=0: frame_active<=1, offset<=0, base latched. If frame_active=1: edge ignored, err_overrun<=1.
- IDLE -> ADDR_SEND when frame_active && !fifo_prog_full. On that transition ARADDR<=base+offset and ARVALID<=1.
- ADDR_SEND: ARVALID and ARADDR held stable until ARVALID&&ARREADY, then ARVALID<=0 and -> DATA_RECV.
- DATA_RECV: RREADY=1 (combinational from state). fifo_wr_en=RVALID&&RREADY. fifo_din=RDATA. beat_cnt (8 bit) increments per beat. A beat with RRESP!=0 sets err_resp. The burst ends on the handshake of the beat carrying RLAST. If RLAST arrives with beat_cnt!=63, err_last<=1. A beat 63 without RLAST also sets err_last and the FSM keeps accepting beats until RLAST. -> NEXT.
- NEXT (one cycle): beat_cnt<=0. If offset==FRAME_BYTES-512: frame_active<=0 and reader_done<=1 for one cycle. Otherwise offset<=offset+512. Then -> IDLE.
- Exactly FRAME_BYTES/512 (300) bursts per frame. Offset never exceeds FRAME_BYTES-512. Offset arithmetic is 32-bit unsigned.
- Sticky error flags clear only on rst.

## Timing
- Reset values: ARVALID=0, ARADDR=0, RREADY=0, fifo_wr_en=0, reader_done=0, frame_active=0, err_*=0, state=IDLE, offset=0, beat_cnt=0.
- rst mid-burst aborts immediately. The AXI slave and FIFO must be reset together with this block.
- ARVALID can first rise 2 cycles after the frame_start edge: 1 cycle for edge detect, then the IDLE decision.
- Zero added latency from RVALID to fifo_wr_en. Back-to-back beats are accepted at 1 beat/cycle.
- fifo_prog_full is checked only in IDLE. Once a burst is issued, all 64 beats are accepted regardless of fifo_prog_full, so the FIFO prog_full threshold must guarantee at least 64 free words.
- Minimum burst-to-burst gap: 2 cycles (NEXT, IDLE).

## Test plan
- Base 0x1000_0000, zero-wait slave, FIFO never full, frame_start edge -> 300 ARADDRs 0x1000_0000..0x1002_5600 in 512-byte steps; 19200 fifo_wr_en beats; reader_done pulses once; frame_active falls.
- fifo_prog_full held high at burst 5 -> ARVALID stays 0 in IDLE; next ARADDR=base+0xA00 on release.
- ARREADY delayed 7 cycles and RVALID toggled every other cycle -> ARADDR stable while ARVALID=1; exactly 64 fifo_wr_en per burst; fifo_din matches RDATA order.
- RLAST on beat 40, and separately RRESP=2'b10 on beat 3 -> err_last=1 and err_resp=1 respectively; the frame still completes with 300 bursts.
- Second frame_start edge at burst 100 -> err_overrun=1; offsets continue undisturbed; reader_done still pulses after burst 300.
- rst asserted mid-DATA_RECV, then a new frame_start -> all outputs return to reset values; the next ARADDR equals base+0.
